// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank
// Purpose  : Rissy register bank with write-first registered read ports and
//            the program counter held in the top register.
// Revision : 1.0
// ============================================================================
module reg_bank #(
    parameter int              DW      = 16,
    parameter int              AW      = 3,
    parameter logic [DW-1:0]   PC_RST  = 16'hFFFE,
    parameter int              PC_STEP = 2,
    parameter int              ZERO_R0 = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w_en,
    input  logic [AW-1:0] write_add,
    input  logic [DW-1:0] write_data,
    input  logic          pc_inc,
    input  logic          pc_load,
    input  logic [DW-1:0] pc_target,
    input  logic [AW-1:0] RA_add,
    input  logic [AW-1:0] RB_add,
    output logic [DW-1:0] data_a,
    output logic [DW-1:0] data_b,
    output logic [DW-1:0] address
);

    localparam int            c_NREG    = 2 ** AW;
    localparam logic [AW-1:0] c_PC_IDX  = '1;
    localparam logic [DW-1:0] c_PC_STEP = DW'(PC_STEP);

    logic [DW-1:0] r_regs [c_NREG];
    logic [DW-1:0] w_next [c_NREG];
    logic [DW-1:0] r_data_a;
    logic [DW-1:0] r_data_b;
    logic [DW-1:0] r_address;
    logic          w_gp_write;

    // A write aimed at the PC index is handled by the PC priority chain below.
    assign w_gp_write = w_en && (write_add != c_PC_IDX)
                        && !((ZERO_R0 != 0) && (write_add == '0));

    always_comb begin
        for (int i = 0; i < c_NREG; i++) begin
            w_next[i] = r_regs[i];
        end
        if (w_gp_write) begin
            w_next[write_add] = write_data;
        end
        if (pc_load) begin
            w_next[c_PC_IDX] = pc_target;
        end else if (w_en && (write_add == c_PC_IDX)) begin
            w_next[c_PC_IDX] = write_data;
        end else if (pc_inc) begin
            w_next[c_PC_IDX] = r_regs[c_PC_IDX] + c_PC_STEP;
        end
    end

    // Read ports and fetch address sample the next-state values (write-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NREG - 1; i++) begin
                r_regs[i] <= '0;
            end
            r_regs[c_PC_IDX] <= PC_RST;
            r_data_a         <= '0;
            r_data_b         <= '0;
            r_address        <= PC_RST;
        end else begin
            for (int i = 0; i < c_NREG; i++) begin
                r_regs[i] <= w_next[i];
            end
            r_data_a  <= w_next[RA_add];
            r_data_b  <= w_next[RB_add];
            r_address <= w_next[c_PC_IDX];
        end
    end

    assign data_a  = r_data_a;
    assign data_b  = r_data_b;
    assign address = r_address;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank
// Purpose  : Scoreboard bench for reg_bank (default, zero-R0 and 32-bit builds).
// Revision : 1.0
// ============================================================================
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_en;
    logic        pc_inc;
    logic        pc_load;
    logic [3:0]  write_add;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] write_data;
    logic [31:0] pc_target;

    logic [15:0] a0, b0, p0, a1, b1, p1;
    logic [31:0] a2, b2, p2;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  dut;
        logic        ca;
        logic        cb;
        logic        cp;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ep;
        logic [95:0] nm;
    } exp_t;

    exp_t sbq [$];

    always #5 clk = ~clk;

    reg_bank u_dut0 (
        .clk(clk), .rst(rst), .w_en(w_en), .write_add(write_add[2:0]),
        .write_data(write_data[15:0]), .pc_inc(pc_inc), .pc_load(pc_load),
        .pc_target(pc_target[15:0]), .RA_add(ra[2:0]), .RB_add(rb[2:0]),
        .data_a(a0), .data_b(b0), .address(p0)
    );

    reg_bank #(.ZERO_R0(1)) u_dut1 (
        .clk(clk), .rst(rst), .w_en(w_en), .write_add(write_add[2:0]),
        .write_data(write_data[15:0]), .pc_inc(pc_inc), .pc_load(pc_load),
        .pc_target(pc_target[15:0]), .RA_add(ra[2:0]), .RB_add(rb[2:0]),
        .data_a(a1), .data_b(b1), .address(p1)
    );

    reg_bank #(.DW(32), .AW(4), .PC_RST(32'h0), .PC_STEP(4)) u_dut2 (
        .clk(clk), .rst(rst), .w_en(w_en), .write_add(write_add),
        .write_data(write_data), .pc_inc(pc_inc), .pc_load(pc_load),
        .pc_target(pc_target), .RA_add(ra), .RB_add(rb),
        .data_a(a2), .data_b(b2), .address(p2)
    );

    // Monitor: one expectation per clock edge, checked just after the edge.
    always @(posedge clk) begin
        exp_t        e;
        logic [31:0] ga, gb, gp;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.dut)
                2'd0:    begin ga = {16'h0, a0}; gb = {16'h0, b0}; gp = {16'h0, p0}; end
                2'd1:    begin ga = {16'h0, a1}; gb = {16'h0, b1}; gp = {16'h0, p1}; end
                default: begin ga = a2; gb = b2; gp = p2; end
            endcase
            if (e.ca) begin
                checks++;
                if (ga !== e.ea) begin
                    failures++;
                    $display("FAIL %s data_a got=%h exp=%h", e.nm, ga, e.ea);
                end
            end
            if (e.cb) begin
                checks++;
                if (gb !== e.eb) begin
                    failures++;
                    $display("FAIL %s data_b got=%h exp=%h", e.nm, gb, e.eb);
                end
            end
            if (e.cp) begin
                checks++;
                if (gp !== e.ep) begin
                    failures++;
                    $display("FAIL %s address got=%h exp=%h", e.nm, gp, e.ep);
                end
            end
        end
    end

    task automatic clr();
        rst = 1'b0; w_en = 1'b0; pc_inc = 1'b0; pc_load = 1'b0;
        write_add = 4'd0; write_data = 32'h0; pc_target = 32'h0;
        ra = 4'd0; rb = 4'd0;
    endtask

    task automatic tick(input logic [1:0] d,
                        input logic ca, input logic [31:0] ea,
                        input logic cb, input logic [31:0] eb,
                        input logic cp, input logic [31:0] ep,
                        input logic [95:0] nm);
        exp_t e;
        e.dut = d; e.ca = ca; e.cb = cb; e.cp = cp;
        e.ea = ea; e.eb = eb; e.ep = ep; e.nm = nm;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        clr();
        @(negedge clk);

        // Reset held two cycles with write and increment requests present.
        rst = 1; w_en = 1; pc_inc = 1; write_add = 3; write_data = 32'hDEAD; ra = 3; rb = 7;
        tick(0, 1, 0, 1, 0, 1, 32'hFFFE, "rst1");
        tick(2, 1, 0, 1, 0, 1, 32'h0, "rst2_wide");
        clr(); ra = 0; rb = 1;
        tick(0, 1, 0, 1, 0, 1, 32'hFFFE, "rst_rd01");
        clr(); ra = 2; rb = 3;
        tick(0, 1, 0, 1, 0, 0, 0, "rst_rd23");

        // Increment from reset value.
        clr(); pc_inc = 1; ra = 4; rb = 5;
        tick(0, 1, 0, 1, 0, 1, 32'h0000, "inc1");
        clr(); pc_inc = 1; ra = 6; rb = 1;
        tick(0, 1, 0, 1, 0, 1, 32'h0002, "inc2");
        clr(); pc_inc = 1; ra = 7; rb = 2;
        tick(0, 1, 32'h0004, 1, 0, 1, 32'h0004, "inc3_rdpc");

        // Write-first bypass.
        clr(); w_en = 1; write_add = 3; write_data = 32'hA5A5; ra = 3; rb = 3;
        tick(0, 1, 32'hA5A5, 1, 32'hA5A5, 1, 32'h0004, "bypass");
        clr(); w_en = 1; write_add = 2; write_data = 32'h1234; ra = 2; rb = 3;
        tick(0, 1, 32'h1234, 1, 32'hA5A5, 0, 0, "wr_r2");
        clr(); ra = 2; rb = 3;
        tick(0, 1, 32'h1234, 1, 32'hA5A5, 1, 32'h0004, "hold_rd");

        // Wrap at the top of the address space.
        clr(); pc_load = 1; pc_target = 32'hFFFE;
        tick(0, 0, 0, 0, 0, 1, 32'hFFFE, "load_fffe");
        clr(); pc_inc = 1;
        tick(0, 0, 0, 0, 0, 1, 32'h0000, "wrap");

        // PC request priority.
        clr(); pc_load = 1; pc_target = 32'h0100; w_en = 1; write_add = 7;
        write_data = 32'h0200; pc_inc = 1; ra = 7;
        tick(0, 1, 32'h0100, 0, 0, 1, 32'h0100, "pri_load");
        clr(); w_en = 1; write_add = 7; write_data = 32'h0200; pc_inc = 1; rb = 7;
        tick(0, 0, 0, 1, 32'h0200, 1, 32'h0200, "pri_write");
        clr(); pc_inc = 1;
        tick(0, 0, 0, 0, 0, 1, 32'h0202, "pri_inc");

        // Reset mid-sequence discards a concurrent write.
        clr(); rst = 1; w_en = 1; write_add = 3; write_data = 32'hFFFF;
        tick(0, 1, 0, 1, 0, 1, 32'hFFFE, "rst_mid");
        clr(); ra = 3; rb = 2;
        tick(0, 1, 0, 1, 0, 1, 32'hFFFE, "rst_mid_rd");

        // Register 0 behaviour with and without ZERO_R0.
        clr(); w_en = 1; write_add = 0; write_data = 32'hFFFF; ra = 0; rb = 0;
        tick(1, 1, 0, 1, 0, 1, 32'hFFFE, "z_r0_wr");
        clr(); w_en = 1; write_add = 1; write_data = 32'hBEEF; ra = 1; rb = 0;
        tick(1, 1, 32'hBEEF, 1, 0, 0, 0, "z_r1_wr");
        clr(); ra = 0; rb = 1;
        tick(0, 1, 32'hFFFF, 1, 32'hBEEF, 0, 0, "nz_r0_rd");

        // Wide build: PC in register 15, step 4, reset value 0.
        clr(); rst = 1;
        tick(2, 1, 0, 1, 0, 1, 32'h0, "w_rst");
        clr(); pc_inc = 1;
        tick(2, 0, 0, 0, 0, 1, 32'h4, "w_inc1");
        clr(); pc_inc = 1;
        tick(2, 0, 0, 0, 0, 1, 32'h8, "w_inc2");
        clr(); w_en = 1; write_add = 15; write_data = 32'h8000_0000; rb = 15;
        tick(2, 0, 0, 1, 32'h8000_0000, 1, 32'h8000_0000, "w_pcwr");
        clr(); w_en = 1; write_add = 9; write_data = 32'h1234_5678; ra = 9; rb = 15;
        tick(2, 1, 32'h1234_5678, 1, 32'h8000_0000, 1, 32'h8000_0000, "w_r9");

        clr();
        tick(0, 0, 0, 0, 0, 0, 0, "drain");
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain queue_left got=%0d exp=0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
